// File: rtl/dsp_mac_pkg.sv
// Shared types and opmode constants for the DSP dot-product sequencer.
// Opmode encoding: [1:0] X mux, [3:2] Z mux (00 zero, 10 P, 11 C).
package dsp_mac_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_FEED,
    ST_DRAIN,
    ST_DONE
  } state_e;

  localparam logic [7:0] OPM_FIRST     = 8'h01;
  localparam logic [7:0] OPM_FIRST_RND = 8'h0D;
  localparam logic [7:0] OPM_ACC       = 8'h09;

  function automatic logic ce_state(input state_e s);
    return s inside {ST_CLEAR, ST_FEED, ST_DRAIN};
  endfunction

endpackage

// File: rtl/dsp_mac_dly.sv
// Parameterised shift delay line for opmode and valid tags.
// DLY = 0 degenerates to a wire.
module dsp_mac_dly #(
  parameter int W   = 8,
  parameter int DLY = 1
) (
  input  logic         CLK,
  input  logic         RSTA,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  generate
    if (DLY == 0) begin : g_wire
      assign dout = din;
    end else begin : g_sr
      logic [W-1:0] sr_q [DLY];
      logic [W-1:0] sr_d [DLY];

      always_comb begin
        sr_d[0] = din;
        for (int i = 1; i < DLY; i++) begin
          sr_d[i] = sr_q[i-1];
        end
      end

      always_ff @(posedge CLK or posedge RSTA) begin
        if (RSTA) begin
          for (int i = 0; i < DLY; i++) begin
            sr_q[i] <= '0;
          end
        end else begin
          sr_q <= sr_d;
        end
      end

      assign dout = sr_q[DLY-1];
    end
  endgenerate

endmodule

// File: rtl/dsp_mac_seq.sv
// Dot-product sequencer driving an external pipelined DSP slice.
// Define DSP_MAC_SEQ_ROUND_EN to add a round-half-up bias via C.
module dsp_mac_seq
  import dsp_mac_pkg::*;
#(
  parameter int LEN_W    = 8,
  parameter int PIPE_LAT = 3,
  parameter int OPM_DLY  = 1,
  parameter int RND_SH   = 16
) (
  input  logic             CLK,
  input  logic             RSTA,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [17:0]      s_a,
  input  logic [17:0]      s_b,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [47:0]      m_data,
  output logic             busy,
  output logic [17:0]      dsp_a,
  output logic [17:0]      dsp_b,
  output logic [17:0]      dsp_d,
  output logic [47:0]      dsp_c,
  output logic [7:0]       dsp_opmode,
  output logic             dsp_ce,
  output logic             dsp_rst,
  input  logic [47:0]      dsp_p
);

`ifdef DSP_MAC_SEQ_ROUND_EN
  localparam bit RND_EN = 1'b1;
`else
  localparam bit RND_EN = 1'b0;
`endif

  localparam logic [7:0]  OPM_FST = RND_EN ? OPM_FIRST_RND : OPM_FIRST;
  localparam logic [47:0] C_VAL   =
    RND_EN ? (48'd1 << (RND_SH - 1)) : 48'd0;
  localparam logic [7:0]  DRN     = 8'(PIPE_LAT + OPM_DLY - 1);

  state_e            state_q, state_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic [7:0]        dcnt_q, dcnt_d;
  logic              first_q, first_d;
  logic [47:0]       m_data_q, m_data_d;
  logic              m_valid_q, m_valid_d;
  logic              s_ready_q, s_ready_d;
  logic              busy_q, busy_d;
  logic              ce_q, ce_d;
  logic              rst_q, rst_d;
  logic [17:0]       a_q, a_d;
  logic [17:0]       b_q, b_d;
  logic [7:0]        op_q, op_d;
  logic [47:0]       c_q;
  logic              hs;

  assign hs = s_ready_q && s_valid;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    dcnt_d   = dcnt_q;
    first_d  = first_q;
    m_data_d = m_data_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          cnt_d   = len;
          first_d = 1'b1;
          state_d = ST_CLEAR;
        end
      end
      ST_CLEAR: begin
        if (cnt_q == '0) begin
          m_data_d = '0;
          state_d  = ST_DONE;
        end else begin
          state_d = ST_FEED;
        end
      end
      ST_FEED: begin
        if (hs) begin
          cnt_d   = cnt_q - LEN_W'(1);
          first_d = 1'b0;
          if (cnt_q == LEN_W'(1)) begin
            dcnt_d  = DRN;
            state_d = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if (dcnt_q == '0) begin
          m_data_d = dsp_p;
          state_d  = ST_DONE;
        end else begin
          dcnt_d = dcnt_q - 8'd1;
        end
      end
      ST_DONE: begin
        if (m_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Bubbles and drain cycles feed zeros with accumulate so P holds.
  always_comb begin
    a_d  = '0;
    b_d  = '0;
    op_d = '0;
    if (hs) begin
      a_d  = s_a;
      b_d  = s_b;
      op_d = first_q ? OPM_FST : OPM_ACC;
    end else if (ce_state(state_d)) begin
      op_d = OPM_ACC;
    end
  end

  always_comb begin
    m_valid_d = (state_d == ST_DONE);
    s_ready_d = (state_d == ST_FEED);
    busy_d    = (state_d != ST_IDLE);
    ce_d      = ce_state(state_d);
    rst_d     = (state_d == ST_CLEAR);
  end

  always_ff @(posedge CLK or posedge RSTA) begin
    if (RSTA) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      dcnt_q    <= '0;
      first_q   <= 1'b0;
      m_data_q  <= '0;
      m_valid_q <= 1'b0;
      s_ready_q <= 1'b0;
      busy_q    <= 1'b0;
      ce_q      <= 1'b0;
      rst_q     <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      op_q      <= '0;
      c_q       <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      dcnt_q    <= dcnt_d;
      first_q   <= first_d;
      m_data_q  <= m_data_d;
      m_valid_q <= m_valid_d;
      s_ready_q <= s_ready_d;
      busy_q    <= busy_d;
      ce_q      <= ce_d;
      rst_q     <= rst_d;
      a_q       <= a_d;
      b_q       <= b_d;
      op_q      <= op_d;
      c_q       <= C_VAL;
    end
  end

  dsp_mac_dly #(
    .W   (8),
    .DLY (OPM_DLY)
  ) u_opm_dly (
    .CLK  (CLK),
    .RSTA (RSTA),
    .din  (op_q),
    .dout (dsp_opmode)
  );

  assign s_ready = s_ready_q;
  assign m_valid = m_valid_q;
  assign m_data  = m_data_q;
  assign busy    = busy_q;
  assign dsp_a   = a_q;
  assign dsp_b   = b_q;
  assign dsp_d   = '0;
  assign dsp_c   = c_q;
  assign dsp_ce  = ce_q;
  assign dsp_rst = rst_q;

endmodule

// File: tb/tb_dsp_mac_seq.sv
// Scoreboard bench for dsp_mac_seq with a behavioural DSP slice.
// Build with DSP_MAC_SEQ_ROUND_EN to exercise the rounding bias.
module tb_dsp_mac_seq;

  localparam int LEN_W    = 8;
  localparam int PIPE_LAT = 3;
  localparam int OPM_DLY  = 1;
  localparam int RND_SH   = 4;

`ifdef DSP_MAC_SEQ_ROUND_EN
  localparam logic [47:0] BIAS = 48'd8;
`else
  localparam logic [47:0] BIAS = 48'd0;
`endif

  logic             CLK = 1'b0;
  logic             RSTA = 1'b1;
  logic             start = 1'b0;
  logic [LEN_W-1:0] len = '0;
  logic             s_valid = 1'b0;
  logic             s_ready;
  logic [17:0]      s_a = '0;
  logic [17:0]      s_b = '0;
  logic             m_valid;
  logic             m_ready = 1'b1;
  logic [47:0]      m_data;
  logic             busy;
  logic [17:0]      dsp_a, dsp_b, dsp_d;
  logic [47:0]      dsp_c;
  logic [7:0]       dsp_opmode;
  logic             dsp_ce, dsp_rst;
  logic [47:0]      dsp_p;

  dsp_mac_seq #(
    .LEN_W    (LEN_W),
    .PIPE_LAT (PIPE_LAT),
    .OPM_DLY  (OPM_DLY),
    .RND_SH   (RND_SH)
  ) dut (
    .CLK        (CLK),
    .RSTA       (RSTA),
    .start      (start),
    .len        (len),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_a        (s_a),
    .s_b        (s_b),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .busy       (busy),
    .dsp_a      (dsp_a),
    .dsp_b      (dsp_b),
    .dsp_d      (dsp_d),
    .dsp_c      (dsp_c),
    .dsp_opmode (dsp_opmode),
    .dsp_ce     (dsp_ce),
    .dsp_rst    (dsp_rst),
    .dsp_p      (dsp_p)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  // Behavioural DSP: A/B reg -> M reg -> P reg, opmode registered once.
  logic [17:0]        a_r = '0, b_r = '0;
  logic [47:0]        m_r = '0, p_r = '0;
  logic [7:0]         opm_r = '0;
  logic signed [35:0] prod;
  logic [47:0]        xv, zv;

  assign prod = $signed(a_r) * $signed(b_r);

  always_comb begin
    xv = (opm_r[1:0] == 2'b01) ? m_r : 48'd0;
    case (opm_r[3:2])
      2'b10:   zv = p_r;
      2'b11:   zv = dsp_c;
      default: zv = 48'd0;
    endcase
  end

  always @(posedge CLK) begin
    if (dsp_rst) begin
      a_r <= '0; b_r <= '0; m_r <= '0; p_r <= '0; opm_r <= '0;
    end else if (dsp_ce) begin
      a_r   <= dsp_a;
      b_r   <= dsp_b;
      m_r   <= {{12{prod[35]}}, prod};
      opm_r <= dsp_opmode;
      p_r   <= zv + xv;
    end
  end

  assign dsp_p = p_r;

  typedef struct {
    logic [47:0] data;
    int          st;
    int          lat;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   n_chk = 0;
  int   n_pass = 0;
  int   st_cyc = 0;

  function automatic void chk(input string nm,
                              input logic [63:0] act,
                              input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endfunction

  // Monitor: pop on every result handshake.
  logic mv_prev = 1'b0;
  int   rise_cyc = 0;
  always @(negedge CLK) begin
    if (m_valid && !mv_prev) rise_cyc = cyc;
    mv_prev = m_valid;
    if (m_valid && m_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_result", 64'(m_data), 64'hDEAD);
      end else begin
        e = sb.pop_front();
        chk("m_data", 64'(m_data), 64'(e.data));
        chk("latency", 64'(rise_cyc - e.st), 64'(e.lat));
      end
    end
  end

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic push(input logic [47:0] d, input int lat);
    exp_t x;
    x.data = d;
    x.st   = st_cyc;
    x.lat  = lat;
    sb.push_back(x);
  endtask

  task automatic go(input int n);
    start  = 1'b1;
    len    = LEN_W'(n);
    st_cyc = cyc;
    tick();
    start = 1'b0;
    chk("clear_state", 64'({busy, dsp_rst, dsp_ce}), 64'h7);
  endtask

  task automatic send(input logic [17:0] a, input logic [17:0] b);
    int   t;
    logic ok;
    t  = 0;
    ok = 1'b0;
    s_valid = 1'b1;
    s_a = a;
    s_b = b;
    while (!ok && t < 50) begin
      @(negedge CLK);
      ok = s_ready;
      tick();
      t++;
    end
    if (!ok) chk("s_ready_timeout", 64'(ok), 64'h1);
    s_valid = 1'b0;
  endtask

  task automatic bubble;
    s_valid = 1'b0;
    tick();
  endtask

  task automatic wait_idle;
    int t;
    t = 0;
    while (busy && t < 200) begin
      tick();
      t++;
    end
    chk("idle_timeout", 64'(busy), 64'h0);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ctl"}, 64'({s_ready, m_valid, busy, dsp_ce, dsp_rst}), 0);
    chk({tag, "_mdata"}, 64'(m_data), 0);
    chk({tag, "_dsp_ab"}, 64'({dsp_a, dsp_b, dsp_d}), 0);
    chk({tag, "_dsp_opm_c"}, 64'({dsp_opmode, dsp_c}), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    logic sr_seen;
    logic bsy_seen;

    repeat (3) tick();
    chk_zero("reset");
    RSTA = 1'b0;
    tick();

    // len=4 back-to-back: 2+12+30+56
    go(4);
    push(48'd100 + BIAS, 1 + 4 + PIPE_LAT + OPM_DLY + 1);
    send(18'd1, 18'd2);
    send(18'd3, 18'd4);
    send(18'd5, 18'd6);
    send(18'd7, 18'd8);
    wait_idle();

    // len=3 with one bubble
    go(3);
    push(48'd12 + BIAS, 1 + 3 + 1 + PIPE_LAT + OPM_DLY + 1);
    send(18'd2, 18'd2);
    bubble();
    send(18'd2, 18'd2);
    send(18'd2, 18'd2);
    wait_idle();

    // len=0: straight to DONE with zero
    go(0);
    push(48'd0, 2);
    sr_seen = 1'b0;
    repeat (4) begin
      @(negedge CLK);
      sr_seen = sr_seen | s_ready;
    end
    tick();
    chk("len0_no_sready", 64'(sr_seen), 0);
    wait_idle();

    // signed: -3*5 + 2*1 = -13
    go(2);
    push(48'hFFFF_FFFF_FFF3 + BIAS, 1 + 2 + PIPE_LAT + OPM_DLY + 1);
    send(18'h3FFFD, 18'd5);
    send(18'd2, 18'd1);
    wait_idle();

    // most negative squared = 2^34
    go(1);
    push(48'h4_0000_0000 + BIAS, 1 + 1 + PIPE_LAT + OPM_DLY + 1);
    send(18'h20000, 18'h20000);
    wait_idle();

    // backpressure in DONE, start pulse ignored
    m_ready = 1'b0;
    go(2);
    push(48'd101 + BIAS, 1 + 2 + PIPE_LAT + OPM_DLY + 1);
    send(18'd10, 18'd10);
    send(18'd1, 18'd1);
    begin
      int t;
      t = 0;
      while (!m_valid && t < 50) begin
        tick();
        t++;
      end
    end
    chk("done_timeout", 64'(m_valid), 64'h1);
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      chk("hold_valid", 64'(m_valid), 64'h1);
      chk("hold_data", 64'(m_data), 64'(48'd101 + BIAS));
      tick();
      start = (i == 3);
      len   = 8'd5;
    end
    start   = 1'b0;
    m_ready = 1'b1;
    @(negedge CLK);
    tick();
    @(negedge CLK);
    chk("mvalid_fall", 64'(m_valid), 0);
    bsy_seen = 1'b0;
    repeat (3) begin
      @(negedge CLK);
      bsy_seen = bsy_seen | busy;
    end
    tick();
    chk("start_ignored", 64'(bsy_seen), 0);

    // reset mid-FEED after 2 of 5 beats
    go(5);
    send(18'd1, 18'd1);
    send(18'd2, 18'd2);
    s_valid = 1'b1;
    chk("pre_reset_feed", 64'({busy, s_ready, dsp_ce}), 64'h7);
    RSTA = 1'b1;
    #1;
    chk_zero("midrst");
    s_valid = 1'b0;
    tick();
    RSTA = 1'b0;
    tick();
    go(1);
    push(48'd9 + BIAS, 1 + 1 + PIPE_LAT + OPM_DLY + 1);
    send(18'd3, 18'd3);
    wait_idle();

    repeat (3) tick();
    chk("sb_empty", 64'(sb.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
